// File: rtl/rasterix_cmd_dispatcher_if.sv
// Command-stream bundle between the host, the dispatcher and the rasterizer cores.
// The slave modport is the dispatcher's view; the master modport is the host/core side.
interface rasterix_cmd_dispatcher_if #(
    parameter int NUM_CORES        = 2,
    parameter int CMD_STREAM_WIDTH = 32
);
    logic                                  s_cmd_axis_tvalid;
    logic                                  s_cmd_axis_tready;
    logic                                  s_cmd_axis_tlast;
    logic [CMD_STREAM_WIDTH-1:0]           s_cmd_axis_tdata;
    logic [NUM_CORES-1:0]                  m_cmd_axis_tvalid;
    logic [NUM_CORES-1:0]                  m_cmd_axis_tready;
    logic [NUM_CORES-1:0]                  m_cmd_axis_tlast;
    logic [NUM_CORES*CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata;

    modport slave (
        input  s_cmd_axis_tvalid, s_cmd_axis_tlast, s_cmd_axis_tdata, m_cmd_axis_tready,
        output s_cmd_axis_tready, m_cmd_axis_tvalid, m_cmd_axis_tlast, m_cmd_axis_tdata
    );

    modport master (
        output s_cmd_axis_tvalid, s_cmd_axis_tlast, s_cmd_axis_tdata, m_cmd_axis_tready,
        input  s_cmd_axis_tready, m_cmd_axis_tvalid, m_cmd_axis_tlast, m_cmd_axis_tdata
    );
endinterface

// File: rtl/rasterix_cmd_dispatcher.sv
// Packet-granular router: consumes a one-word routing header per packet and fans the
// payload out (unicast / broadcast / round-robin) through a registered output slice.
module rasterix_cmd_dispatcher #(
    parameter int NUM_CORES        = 2,
    parameter int CMD_STREAM_WIDTH = 32,
    parameter int DEST_WIDTH       = 8
) (
    input  logic                            aclk,
    input  logic                            resetn,
    rasterix_cmd_dispatcher_if.slave        cmd,
    output logic                            busy,
    output logic                            err_bad_header
);
    localparam int W    = CMD_STREAM_WIDTH;
    localparam int RR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_CORES-1:0] r_mask, w_mask_nxt, w_hdr_mask;
    logic [NUM_CORES-1:0] r_valid, w_valid_nxt;
    logic                 r_rr_mode, w_rr_mode_nxt;
    logic [RR_W-1:0]      r_rr_ptr, w_rr_ptr_nxt, w_rr_inc;
    logic                 r_last, w_last_nxt;
    logic [W-1:0]         r_data, w_data_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_slice_free, w_in_ready, w_accept, w_hdr_bad;
    logic [1:0]           w_mode;
    logic [DEST_WIDTH-1:0] w_dest;

    assign w_mode = cmd.s_cmd_axis_tdata[W-1 -: 2];
    assign w_dest = cmd.s_cmd_axis_tdata[DEST_WIDTH-1:0];

    // A new word may enter only if no targeted channel is still stalled this cycle.
    assign w_slice_free = ~|(r_valid & ~cmd.m_cmd_axis_tready);
    assign w_in_ready   = resetn & ((r_state == DROP) | w_slice_free);
    assign w_accept     = cmd.s_cmd_axis_tvalid & w_in_ready;
    assign w_rr_inc     = (r_rr_ptr == RR_W'(NUM_CORES - 1)) ? '0 : r_rr_ptr + 1'b1;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_hdr_mask = '0;
        w_hdr_bad  = 1'b0;
        case (w_mode)
            2'b00: begin
                w_hdr_bad = 32'(w_dest) >= 32'(NUM_CORES);
                for (int i = 0; i < NUM_CORES; i++) w_hdr_mask[i] = (32'(w_dest) == i);
            end
            2'b01:   w_hdr_mask = '1;
            2'b10: begin
                for (int i = 0; i < NUM_CORES; i++) w_hdr_mask[i] = (32'(r_rr_ptr) == i);
            end
            default: w_hdr_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_mask;
        w_rr_mode_nxt = r_rr_mode;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_valid_nxt   = r_valid & ~cmd.m_cmd_axis_tready;
        w_data_nxt    = r_data;
        w_last_nxt    = r_last;
        w_err_nxt     = 1'b0;
        unique case (r_state)
            IDLE: if (w_accept) begin
                if (w_hdr_bad) begin
                    w_err_nxt = 1'b1;
                    if (!cmd.s_cmd_axis_tlast) w_state_nxt = DROP;
                end else if (cmd.s_cmd_axis_tlast) begin
                    // Empty packet: nothing forwarded, but a round-robin slot is still spent.
                    if (w_mode == 2'b10) w_rr_ptr_nxt = w_rr_inc;
                end else begin
                    w_state_nxt   = STREAM;
                    w_mask_nxt    = w_hdr_mask;
                    w_rr_mode_nxt = (w_mode == 2'b10);
                end
            end
            STREAM: if (w_accept) begin
                w_valid_nxt = r_mask;
                w_data_nxt  = cmd.s_cmd_axis_tdata;
                w_last_nxt  = cmd.s_cmd_axis_tlast;
                if (cmd.s_cmd_axis_tlast) begin
                    w_state_nxt = IDLE;
                    if (r_rr_mode) w_rr_ptr_nxt = w_rr_inc;
                end
            end
            DROP: if (w_accept && cmd.s_cmd_axis_tlast) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_mask    <= '0;
            r_rr_mode <= 1'b0;
            r_rr_ptr  <= '0;
            r_valid   <= '0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mask    <= w_mask_nxt;
            r_rr_mode <= w_rr_mode_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_valid   <= w_valid_nxt;
            r_data    <= w_data_nxt;
            r_last    <= w_last_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign cmd.s_cmd_axis_tready = w_in_ready;
    assign cmd.m_cmd_axis_tvalid = r_valid;
    assign cmd.m_cmd_axis_tlast  = {NUM_CORES{r_last}};
    assign cmd.m_cmd_axis_tdata  = {NUM_CORES{r_data}};
    assign busy                  = (r_state != IDLE) | (|r_valid);
    assign err_bad_header        = r_err;
endmodule
